// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter and line-fetch sequencer.
//
// One synchronous-read RAM (1-cycle read latency) is shared between:
//   - the display path, which fetches LINE_WORDS consecutive words into a line
//     buffer for each fetch_req pulse, and
//   - a drawing/CPU port that issues single-word reads and writes.
//
// The display fetch has priority. After every SLOT_EVERY consecutive fetch
// issues, one cycle is offered to the CPU port, so a pending CPU request
// waits a bounded time during a line fetch. Outside a fetch the CPU owns the
// RAM and is granted combinationally.
//
// Return path: the cycle after a fetch issue writes mem_rdata into the line
// buffer. The cycle after an accepted CPU read presents mem_rdata on
// cpu_rdata. Only one access is issued per cycle, so the two returns never
// coincide.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 160,
    parameter int unsigned SLOT_EVERY = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,

    // Line-fetch request and status
    input  logic                          fetch_req,
    input  logic [ADDR_W-1:0]             fetch_base,
    output logic                          fetch_busy,
    output logic                          fetch_done,
    output logic                          fetch_overrun,

    // Line-buffer write port
    output logic                          lb_we,
    output logic [$clog2(LINE_WORDS)-1:0] lb_addr,
    output logic [DATA_W-1:0]             lb_wdata,

    // CPU / drawing port
    input  logic                          cpu_valid,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_rvalid,
    output logic [DATA_W-1:0]             cpu_rdata,

    // RAM port
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned LB_W   = $clog2(LINE_WORDS);
    localparam int unsigned SLOT_W = $clog2(SLOT_EVERY + 1);

    typedef enum logic [0:0] {
        StIdle,
        StFetch
    } state_e;

    state_e state_q, state_d;

    logic [LB_W-1:0]   idx_q;         // next line word to issue
    logic [ADDR_W-1:0] base_q;        // line start address
    logic [SLOT_W-1:0] slot_q;        // fetch issues since the last CPU slot
    logic              lb_pend_q;     // a fetch read was issued last cycle
    logic [LB_W-1:0]   lb_idx_q;      // index of that fetch read
    logic              cpu_rd_pend_q; // a CPU read was accepted last cycle
    logic              overrun_q;

    logic fetch_issue;
    logic cpu_grant;
    logic slot_open;
    logic last_idx;

    assign slot_open = (slot_q == SLOT_W'(SLOT_EVERY));
    assign last_idx  = (idx_q == LB_W'(LINE_WORDS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start on fetch_req, leave after issuing the final line word
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_req) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (fetch_issue && last_idx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant decode: CPU owns the RAM in idle, fetch owns it except at open slots
    always_comb begin
        fetch_issue = 1'b0;
        cpu_grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cpu_grant = cpu_valid;
            end
            StFetch: begin
                if (slot_open && cpu_valid) begin
                    cpu_grant = 1'b1;
                end else begin
                    fetch_issue = 1'b1;
                end
            end
            default: begin
                fetch_issue = 1'b0;
                cpu_grant   = 1'b0;
            end
        endcase
    end

    // RAM port and CPU handshake outputs
    always_comb begin
        mem_en    = fetch_issue | cpu_grant;
        mem_we    = cpu_grant & cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (fetch_issue) begin
            // Address arithmetic wraps modulo 2^ADDR_W.
            mem_addr = base_q + ADDR_W'(idx_q);
        end else if (cpu_grant) begin
            mem_addr = cpu_addr;
        end
        if (cpu_grant && cpu_we) begin
            mem_wdata = cpu_wdata;
        end
        cpu_ready = cpu_grant;
    end

    // Fetch sequencing, return-path tracking and the sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            base_q        <= '0;
            slot_q        <= '0;
            lb_pend_q     <= 1'b0;
            lb_idx_q      <= '0;
            cpu_rd_pend_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            lb_pend_q     <= fetch_issue;
            cpu_rd_pend_q <= cpu_grant & ~cpu_we;
            if (fetch_issue) begin
                lb_idx_q <= idx_q;
            end

            // A request during an active fetch is dropped and remembered.
            if (fetch_req && (state_q == StFetch)) begin
                overrun_q <= 1'b1;
            end

            if (state_q == StIdle) begin
                if (fetch_req) begin
                    base_q <= fetch_base;
                    idx_q  <= '0;
                    slot_q <= '0;
                end
            end else if (cpu_grant) begin
                slot_q <= '0;
            end else begin
                idx_q <= idx_q + LB_W'(1);
                // An open slot with no CPU request is forfeited.
                if (slot_open) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_q + SLOT_W'(1);
                end
            end
        end
    end

    // Read-return outputs; data is forced low when no return is due
    always_comb begin
        lb_we         = lb_pend_q;
        lb_addr       = lb_idx_q;
        lb_wdata      = lb_pend_q ? mem_rdata : '0;
        cpu_rvalid    = cpu_rd_pend_q;
        cpu_rdata     = cpu_rd_pend_q ? mem_rdata : '0;
        fetch_done    = lb_pend_q && (lb_idx_q == LB_W'(LINE_WORDS - 1));
        fetch_busy    = (state_q == StFetch) || lb_pend_q;
        fetch_overrun = overrun_q;
    end

endmodule
